fsk_demodulator: RTL and testbench

Receive-side counterpart of the FSK transmitter. It takes a 1-bit FSK square wave, such as the output of the transmitter's fractional clock divider chain looped back or a comparator-sliced line input, and measures each tone period in clk_in cycles. Each period is classified as mark (1) or space (0). A baud timer sampling mid-bit recovers the serial bit stream.

---
 rtl/fsk_demodulator.sv | 89 ++++++++
 tb/tb_fsk_demodulator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fsk_demodulator.sv
// fsk_demodulator: measures fsk_in tone periods and recovers bits; outputs tone, carrier_det, period_out, bit_out/bit_valid
module fsk_demodulator #(
  parameter int CNT_W       = 12,
  parameter int MIN_PERIOD  = 4,
  parameter int THRESH      = 20,
  parameter int LOSS_CYCLES = 64,
  parameter int ACQ_EDGES   = 4,
  parameter int BIT_CYCLES  = 192
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             fsk_in,
  output logic             tone,
  output logic             carrier_det,
  output logic [CNT_W-1:0] period_out,
  output logic             bit_out,
  output logic             bit_valid
);
  localparam int AW = $clog2(ACQ_EDGES + 1);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] LOSS_M1 = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(BIT_CYCLES - 1);
  localparam logic [AW-1:0]    ACQ_END = AW'(ACQ_EDGES - 1);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, period_q, period_d, baud_q, baud_d, cand;
  logic [AW-1:0] acq_q, acq_d;
  logic tone_q, tone_d, carrier_q, carrier_d, bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic rise, accept, lost, measure, track, emit;
  always_comb begin
    rise        = s2_q & ~s3_q;
    cand        = (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;
    accept      = rise && cand >= MIN_P;
    lost        = state_q != IDLE && pcnt_q >= LOSS_M1 && !accept;
    pcnt_d      = accept ? '0 : cand;
    measure     = accept && state_q != IDLE;
    period_d    = measure ? cand : period_q;
    tone_d      = measure ? (cand < THR) : tone_q;
    acq_d       = (accept && state_q == IDLE) ? '0 : (accept && state_q == ACQ) ? acq_q + 1'b1 : acq_q;
    state_d     = lost ? IDLE :
                  (accept && state_q == IDLE) ? ACQ :
                  (accept && state_q == ACQ && acq_q == ACQ_END) ? TRACK : state_q;
    carrier_d   = state_d == TRACK;
    track       = state_q == TRACK && state_d == TRACK;
    emit        = track && baud_q == '0;
    baud_d      = (state_q == ACQ && state_d == TRACK) ? HALF :
                  !track ? baud_q :
                  (tone_d != tone_q) ? HALF :
                  emit ? FULL : baud_q - 1'b1;
    bit_valid_d = emit;
    bit_out_d   = emit ? tone_q : bit_out_q;
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      pcnt_q      <= '0;
      period_q    <= '0;
      baud_q      <= '0;
      acq_q       <= '0;
      state_q     <= IDLE;
      tone_q      <= 1'b0;
      carrier_q   <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      s1_q        <= fsk_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pcnt_q      <= pcnt_d;
      period_q    <= period_d;
      baud_q      <= baud_d;
      acq_q       <= acq_d;
      state_q     <= state_d;
      tone_q      <= tone_d;
      carrier_q   <= carrier_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  assign tone        = tone_q;
  assign carrier_det = carrier_q;
  assign period_out  = period_q;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
endmodule

// File: tb/tb_fsk_demodulator.sv
// tb_fsk_demodulator: scoreboard bench for fsk_demodulator
module tb_fsk_demodulator;
  logic clk_in = 1'b0, reset = 1'b1, fsk_in = 1'b0;
  logic tone, carrier_det, bit_out, bit_valid;
  logic [11:0] period_out;
  int cyc = 0, n_checks = 0, n_fail = 0, n_bits = 0;
  int last_rise_cyc = 0, last_bv_cyc = 0, tone_chg_cyc = 0, lock_cyc = 0;
  logic prev_tone = 1'b0, prev_car = 1'b0, prev_bv = 1'b0;
  bit exp_q[$];
  fsk_demodulator dut (
    .clk_in(clk_in), .reset(reset), .fsk_in(fsk_in), .tone(tone), .carrier_det(carrier_det),
    .period_out(period_out), .bit_out(bit_out), .bit_valid(bit_valid)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk_in) begin
    if (tone !== prev_tone) tone_chg_cyc = cyc;
    if (carrier_det && !prev_car) lock_cyc = cyc;
    if (bit_valid) begin
      n_bits++;
      chk("bv_width", prev_bv, 0);
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("bit_out", bit_out, exp_q.pop_front());
      if (n_bits == 1) chk("lock_to_bit", cyc - lock_cyc, 96);
      else if (n_bits <= 5) chk("cadence", cyc - last_bv_cyc, 192);
      else chk("resync_to_bit", cyc - tone_chg_cyc, 96);
      last_bv_cyc = cyc;
    end
    prev_tone = tone;
    prev_car  = carrier_det;
    prev_bv   = bit_valid;
  end
  task automatic period(input int p, input bit glitch = 1'b0);
    for (int i = 0; i < p; i++) begin
      fsk_in = (i < p / 2) && !(glitch && i == 1);
      if (i == 0) last_rise_cyc = cyc;
      @(negedge clk_in);
    end
  endtask
  task automatic send_bit(input bit b, input int glitch_at = -1);
    exp_q.push_back(b);
    for (int k = 0; k < (b ? 12 : 8); k++) begin
      period(b ? 16 : 24, k == glitch_at);
      if (k == glitch_at) begin
        chk("glitch_period", period_out, 16);
        chk("glitch_tone", tone, 1);
      end
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_tone"}, tone, 0);
    chk({tag, "_carrier"}, carrier_det, 0);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_bit_out"}, bit_out, 0);
    chk({tag, "_bit_valid"}, bit_valid, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int pt[8] = '{19, 20, 16, 3, 17, 4, 16, 16};
    int ep[8] = '{16, 19, 20, 16, 16, 20, 4, 16};
    int et[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    int t;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk_in);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 12; k++) begin
      period(16);
      if (k == 3) chk("acq_not_yet", carrier_det, 0);
      if (k == 4) begin
        chk("lock", carrier_det, 1);
        chk("lock_tone", tone, 1);
        chk("lock_period", period_out, 16);
      end
    end
    send_bit(1'b1, 6);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("space_tone", tone, 0);
    chk("space_period", period_out, 24);
    send_bit(1'b1);
    chk("mark_tone", tone, 1);
    send_bit(1'b0);
    fsk_in = 1'b0;
    t = 0;
    while (carrier_det && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    chk("loss_delay", cyc - last_rise_cyc, 67);
    chk("loss_hold_period", period_out, 24);
    chk("loss_hold_tone", tone, 0);
    repeat (300) @(negedge clk_in);
    chk("bit_count", n_bits, 8);
    for (int n = 1; n <= 5; n++) begin
      period(16);
      chk("relock", carrier_det, n == 5);
    end
    period(16);
    period(16);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    repeat (10) @(negedge clk_in);
    for (int n = 1; n <= 5; n++) begin
      period(16);
      chk("reacq", carrier_det, n == 5);
    end
    for (int i = 0; i < 8; i++) begin
      period(pt[i]);
      chk("bnd_period", period_out, ep[i]);
      chk("bnd_tone", tone, et[i]);
    end
    fsk_in = 1'b0;
    repeat (200) @(negedge clk_in);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_bit_count", n_bits, 8);
    chk("final_carrier", carrier_det, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
